// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM states and flag helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_INC   = 4'h1;
  localparam logic [3:0] OP_NEG   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_PASSA = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SLL   = 4'h8;
  localparam logic [3:0] OP_SRL   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_MUL   = 4'hB;

  typedef enum logic {
    IDLE,
    MULB
  } state_t;

  // Signed overflow of x + y (+cin): both addends share a sign the sum does not.
  function automatic logic add_overflow(input logic x_sign, input logic y_sign,
                                        input logic sum_sign);
    return (x_sign == y_sign) && (sum_sign != x_sign);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH bits kept.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] ma, mb, acc, acc_next;
  logic [CW-1:0]    count;

  assign acc_next = mb[0] ? acc + ma : acc;
  // The final iteration's sum is presented directly so the top can register it on that edge.
  assign product  = acc_next;
  assign done     = busy && (count == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      ma    <= a;
      mb    <= b;
      acc   <= '0;
      count <= CW'(WIDTH);
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      ma    <= ma << 1;
      mb    <= mb >> 1;
      count <= count - 1'b1;
      if (count == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; single-cycle ops plus an iterative multiply.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  state_t           state, state_next;
  logic             accept, is_mul, mul_start;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  assign sh = b[SHW-1:0];

  // All four arithmetic ops share one WIDTH+1 adder; only its operands change.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (opcode)
      OP_INC: begin add_y = '0; add_cin = 1'b1; end
      OP_NEG: begin add_x = ~a; add_y = '0; add_cin = 1'b1; end
      OP_SUB: begin add_y = ~b; add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (opcode)
      OP_ADD, OP_INC, OP_NEG, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_overflow(add_x[WIDTH-1], add_y[WIDTH-1], sum[WIDTH-1]);
      end
      OP_PASSA: alu_res = a;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_SLL:   alu_res = a << sh;
      OP_SRL:   alu_res = a >> sh;
      OP_SRA:   alu_res = $signed(a) >>> sh;
      OP_MUL:   ;
      default:  alu_ill = 1'b1;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = rst_n && (state == IDLE) && !mul_busy && (!out_valid || out_ready);
    case (state)
      IDLE:    if (mul_start) state_next = MULB;
      MULB:    if (mul_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign is_mul    = (opcode == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;

  // zero is registered with the result so it reads 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (mul_done) begin
      result    <= mul_product;
      zero      <= (mul_product == '0);
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b1;
    end else if (mul_start) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      result    <= alu_res;
      zero      <= (alu_res == '0);
      carry     <= alu_c;
      overflow  <= alu_v;
      illegal   <= alu_ill;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign negative = result[WIDTH-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus randomized ops against a reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, negative, zero, carry, overflow, illegal;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic         valid;
    logic [W-1:0] res;
    logic         neg;
    logic         zer;
    logic         cy;
    logic         ov;
    logic         ill;
  } outs_t;

  function automatic outs_t observe();
    outs_t o;
    o.valid = out_valid;
    o.res   = result;
    o.neg   = negative;
    o.zer   = zero;
    o.cy    = carry;
    o.ov    = overflow;
    o.ill   = illegal;
    return o;
  endfunction

  // Reference: plain wide/signed arithmetic straight from the opcode definitions.
  function automatic outs_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    outs_t       e;
    longint      sx, sy, sr;
    logic [63:0] wide;
    logic [4:0]  s;
    e = '0;
    e.valid = 1'b1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = 0;
    s  = y[4:0];
    case (op)
      OP_ADD: begin wide = 64'(x) + 64'(y); e.res = wide[31:0]; e.cy = wide[32]; sr = sx + sy; end
      OP_INC: begin wide = 64'(x) + 64'd1;  e.res = wide[31:0]; e.cy = wide[32]; sr = sx + 1; end
      OP_NEG: begin e.res = 32'd0 - x; e.cy = (x == 0); sr = -sx; end
      OP_SUB: begin e.res = x - y; e.cy = (x >= y); sr = sx - sy; end
      OP_PASSA: e.res = x;
      OP_AND:   e.res = x & y;
      OP_OR:    e.res = x | y;
      OP_XOR:   e.res = x ^ y;
      OP_SLL:   e.res = x << s;
      OP_SRL:   e.res = x >> s;
      OP_SRA:   e.res = $signed(x) >>> s;
      OP_MUL: begin wide = 64'(x) * 64'(y); e.res = wide[31:0]; end
      default:  e.ill = 1'b1;
    endcase
    if (op <= OP_SUB) e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.neg = e.res[31];
    e.zer = (e.res == 0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    opcode   = op;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    outs_t o;
    #3;
    o = observe();
    tests++;
    if (o !== '0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got outs=%h in_ready=%b, want outs=0 in_ready=0", o, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    o = observe();
    tests++;
    if (o !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got outs=%h in_ready=%b, want outs=0 in_ready=1", o, in_ready);
    end
  endtask

  task automatic test_add();
    outs_t o, e;
    out_ready = 1'b1;
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    o = observe();
    e = '{valid:1'b1, res:32'h0, neg:1'b0, zer:1'b1, cy:1'b1, ov:1'b0, ill:1'b0};
    tests++;
    if (o !== e) begin fails++; $display("FAIL add_wrap: got %h want %h", o, e); end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_sub();
    outs_t o, e;
    out_ready = 1'b1;
    issue(OP_SUB, 32'h8000_0000, 32'h1);
    o = observe();
    e = '{valid:1'b1, res:32'h7FFF_FFFF, neg:1'b0, zer:1'b0, cy:1'b1, ov:1'b1, ill:1'b0};
    tests++;
    if (o !== e) begin fails++; $display("FAIL sub_ovf: got %h want %h", o, e); end
    issue(OP_SUB, 32'h3, 32'h5);
    o = observe();
    e = '{valid:1'b1, res:32'hFFFF_FFFE, neg:1'b1, zer:1'b0, cy:1'b0, ov:1'b0, ill:1'b0};
    tests++;
    if (o !== e) begin fails++; $display("FAIL sub_borrow: got %h want %h", o, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    outs_t o, e;
    int ready_seen, early_valid;
    ready_seen  = 0;
    early_valid = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    opcode    = OP_MUL;
    a         = 32'd7;
    b         = 32'd6;
    @(posedge clk); #1;
    for (int k = 1; k <= W; k++) begin
      if (in_ready) ready_seen++;
      if (out_valid) early_valid++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    o = observe();
    e = '{valid:1'b1, res:32'd42, neg:1'b0, zer:1'b0, cy:1'b0, ov:1'b0, ill:1'b0};
    tests++;
    if (o !== e) begin fails++; $display("FAIL mul_result: got %h want %h after %0d edges", o, e, W); end
    tests++;
    if (ready_seen !== 0) begin fails++; $display("FAIL mul_busy_ready: in_ready high %0d cycles, want 0", ready_seen); end
    tests++;
    if (early_valid !== 0) begin fails++; $display("FAIL mul_early_valid: out_valid high %0d cycles early, want 0", early_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    outs_t o, e, ex;
    logic [W-1:0] x, y;
    x = $urandom;
    y = $urandom;
    out_ready = 1'b0;
    issue(OP_SRA, 32'h8000_0000, 32'd4);
    e = '{valid:1'b1, res:32'hF800_0000, neg:1'b1, zer:1'b0, cy:1'b0, ov:1'b0, ill:1'b0};
    o = observe();
    tests++;
    if (o !== e || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_sra: got %h in_ready=%b want %h in_ready=0", o, in_ready, e);
    end
    in_valid = 1'b1;
    opcode   = OP_XOR;
    a        = x;
    b        = y;
    repeat (3) begin @(posedge clk); #1; end
    o = observe();
    tests++;
    if (o !== e || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_hold: got %h in_ready=%b want %h in_ready=0", o, in_ready, e);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready: in_ready=%b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ex = model(OP_XOR, x, y);
    o = observe();
    tests++;
    if (o !== ex) begin fails++; $display("FAIL bp_xor: got %h want %h", o, ex); end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    outs_t o, e;
    out_ready = 1'b1;
    issue(4'hF, 32'd5, 32'd5);
    e = '{valid:1'b1, res:32'h0, neg:1'b0, zer:1'b1, cy:1'b0, ov:1'b0, ill:1'b1};
    o = observe();
    tests++;
    if (o !== e) begin fails++; $display("FAIL illegal_op: got %h want %h", o, e); end
    issue(OP_ADD, 32'd1, 32'd2);
    e = '{valid:1'b1, res:32'd3, neg:1'b0, zer:1'b0, cy:1'b0, ov:1'b0, ill:1'b0};
    o = observe();
    tests++;
    if (o !== e) begin fails++; $display("FAIL illegal_clear: got %h want %h", o, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    outs_t o, e;
    logic [3:0] op;
    int stalls;
    stalls    = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == OP_MUL) op = OP_SLL;
      opcode   = op;
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      if (!in_ready) stalls++;
      e = model(op, a, b);
      @(posedge clk); #1;
      o = observe();
      tests++;
      if (o !== e) begin fails++; $display("FAIL b2b_%0d: op=%h got %h want %h", i, op, o, e); end
    end
    in_valid = 1'b0;
    tests++;
    if (stalls !== 0) begin fails++; $display("FAIL b2b_stall: in_ready low %0d times, want 0", stalls); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    outs_t o, e;
    logic [3:0] op;
    logic [W-1:0] x, y;
    int n, hold;
    for (int i = 0; i < 20; i++) begin
      op = (i % 4 == 0) ? OP_MUL : 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = (i % 8 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      e  = model(op, x, y);
      out_ready = 1'b0;
      issue(op, x, y);
      n = 0;
      while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
      o = observe();
      tests++;
      if (o !== e) begin fails++; $display("FAIL rand_%0d: op=%h got %h want %h (waited %0d)", i, op, o, e, n); end
      hold = $urandom_range(0, 3);
      repeat (hold) begin @(posedge clk); #1; end
      o = observe();
      tests++;
      if (o !== e) begin fails++; $display("FAIL rand_hold_%0d: got %h want %h", i, o, e); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL rand_drain_%0d: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    outs_t o, e;
    int late_valid;
    late_valid = 0;
    out_ready  = 1'b1;
    issue(OP_MUL, 32'd3, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    o = observe();
    tests++;
    if (o !== '0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL midmul_reset: got %h in_ready=%b want 0/0", o, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL midmul_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    for (int k = 0; k < 36; k++) begin
      if (out_valid) late_valid++;
      @(posedge clk); #1;
    end
    tests++;
    if (late_valid !== 0) begin fails++; $display("FAIL midmul_abort: out_valid high %0d cycles, want 0", late_valid); end
    issue(OP_ADD, 32'd2, 32'd2);
    e = '{valid:1'b1, res:32'd4, neg:1'b0, zer:1'b0, cy:1'b0, ov:1'b0, ill:1'b0};
    o = observe();
    tests++;
    if (o !== e) begin fails++; $display("FAIL midmul_add: got %h want %h", o, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
